// File: rtl/cmd_dispatch_queue.sv
// -----------------------------------------------------------------------------
// cmd_dispatch_queue
// Feeds 2-bit state commands to the UDP command sender. Commands are buffered
// in a small FIFO and issued one at a time as a single-cycle cmd_valid pulse.
// The next command is issued only after tx_done. A per-attempt timeout with
// bounded retry keeps a hung Ethernet path from stalling the queue.
//
// Optional build macro: CMD_DEDUP_EN
//   Defined  : a push equal to the most recently accepted command is dropped
//              silently while that command is still queued or in flight.
//   Undefined: every push is queued; no duplicate comparison exists.
// -----------------------------------------------------------------------------
module cmd_dispatch_queue #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYC     = 4
) (
  input  logic                          clk_50,
  input  logic                          sys_rst,
  input  logic                          evt_valid,
  input  logic [1:0]                    evt_cmd,
  output logic                          evt_ready,
  output logic [1:0]                    cmd_out,
  output logic                          cmd_valid,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          timeout_err
);

  // Pointer/index widths: pointers carry one extra wrap bit.
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  // Counter widths, never narrower than one bit.
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_ONE = RW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  // Dispatcher states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // FIFO storage and bookkeeping.
  logic [1:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] level_r;
  logic          full_s;
  logic [1:0]    head_s;

  // Dispatcher state and counters.
  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [TW-1:0] to_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic [RW-1:0] retry_cnt_r;

  // Control strobes.
  logic          pop_s;
  logic          retry_s;
  logic          drop_s;
  logic          dup_s;
  logic          push_req_s;
  logic          push_s;
  logic          ovf_set_s;
  logic          issue_s;

  // Registered outputs.
  logic [1:0]    cmd_out_r;
  logic          cmd_valid_r;
  logic          busy_r;
  logic          overflow_r;
  logic          timeout_err_r;

`ifdef CMD_DEDUP_EN
  // Most recently accepted command, used by the duplicate filter.
  logic [1:0]    last_cmd_r;
`endif

  // Full when the wrap bits differ and the index bits match.
  assign full_s = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                  (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]);
  assign head_s = mem_r[rd_ptr_r[IW-1:0]];

  assign evt_ready   = ~full_s;
  assign fifo_level  = level_r;
  assign cmd_out     = cmd_out_r;
  assign cmd_valid   = cmd_valid_r;
  assign busy        = busy_r;
  assign overflow    = overflow_r;
  assign timeout_err = timeout_err_r;

  // Next-state decode; pop/retry/drop strobes for the current head.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    retry_s     = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (level_r != {PW{1'b0}}) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A tx_done landing on the timeout cycle still counts as success.
        if (tx_done) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_GAP;
        end else if (to_cnt_r == TO_LAST) begin
          state_nxt_s = ST_GAP;
          if (retry_cnt_r < RETRY_MAX) begin
            retry_s = 1'b1;
          end else begin
            pop_s  = 1'b1;
            drop_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        // Guaranteed low time so the sender always sees a fresh rising edge.
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Issue strobe: the IDLE -> ISSUE transition.
  always_comb begin
    if ((state_r == ST_IDLE) && (state_nxt_s == ST_ISSUE)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Push acceptance: duplicate filter first, then space (a same-cycle pop frees a slot).
  always_comb begin
`ifdef CMD_DEDUP_EN
    // The newest FIFO entry is always the last accepted command, so it is
    // still pending exactly while the FIFO holds anything.
    if (evt_valid && (level_r != {PW{1'b0}}) && (evt_cmd == last_cmd_r)) begin
      dup_s = 1'b1;
    end else begin
      dup_s = 1'b0;
    end
`else
    dup_s = 1'b0;
`endif
    push_req_s = evt_valid & ~dup_s;
    push_s     = push_req_s & (~full_s | pop_s);
    ovf_set_s  = push_req_s & ~push_s;
  end

  // FIFO data write; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk_50) begin
    if (push_s) begin
      mem_r[wr_ptr_r[IW-1:0]] <= evt_cmd;
    end
  end

  // FIFO pointers and level; a push and pop together leave the level unchanged.
  always_ff @(posedge clk_50) begin
    if (sys_rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + PTR_ONE;
        2'b01:   level_r <= level_r - PTR_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Dispatcher state, per-attempt timeout, gap and retry counters.
  always_ff @(posedge clk_50) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      to_cnt_r    <= {TW{1'b0}};
      gap_cnt_r   <= {GW{1'b0}};
      retry_cnt_r <= {RW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
        to_cnt_r <= to_cnt_r + TO_ONE;
      end else begin
        to_cnt_r <= {TW{1'b0}};
      end
      if ((state_r == ST_GAP) && (state_nxt_s == ST_GAP)) begin
        gap_cnt_r <= gap_cnt_r + GAP_ONE;
      end else begin
        gap_cnt_r <= {GW{1'b0}};
      end
      if (retry_s) begin
        retry_cnt_r <= retry_cnt_r + RETRY_ONE;
      end else if (pop_s) begin
        retry_cnt_r <= {RW{1'b0}};
      end else begin
        retry_cnt_r <= retry_cnt_r;
      end
    end
  end

  // Output registers: issue pulse, held command, busy, sticky overflow, drop pulse.
  always_ff @(posedge clk_50) begin
    if (sys_rst) begin
      cmd_out_r     <= 2'b00;
      cmd_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      overflow_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      cmd_valid_r   <= issue_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      timeout_err_r <= drop_s;
      if (issue_s) begin
        cmd_out_r <= head_s;
      end else begin
        cmd_out_r <= cmd_out_r;
      end
      // Clear wins over a same-cycle dropped push.
      if (ovf_clr) begin
        overflow_r <= 1'b0;
      end else if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

`ifdef CMD_DEDUP_EN
  // Remember the most recently accepted command for the duplicate filter.
  always_ff @(posedge clk_50) begin
    if (sys_rst) begin
      last_cmd_r <= 2'b00;
    end else if (push_s) begin
      last_cmd_r <= evt_cmd;
    end else begin
      last_cmd_r <= last_cmd_r;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_cmd_dispatch_queue
// Directed scenarios followed by a randomized run. Expected outputs come from a
// transaction-level model: a command queue plus issue/settle times computed
// arithmetically from the issue edge, the timeout window and the gap length.
// -----------------------------------------------------------------------------
module tb_cmd_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int T     = 100;
  localparam int R     = 2;
  localparam int G     = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_50 = 1'b0;
  logic          sys_rst = 1'b1;
  logic          evt_valid = 1'b0;
  logic [1:0]    evt_cmd = 2'b00;
  logic          tx_done = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          evt_ready;
  logic [1:0]    cmd_out;
  logic          cmd_valid;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          timeout_err;

  always #10 clk_50 = ~clk_50;

  cmd_dispatch_queue #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(T),
    .MAX_RETRY  (R),
    .GAP_CYC    (G)
  ) dut (
    .clk_50     (clk_50),
    .sys_rst    (sys_rst),
    .evt_valid  (evt_valid),
    .evt_cmd    (evt_cmd),
    .evt_ready  (evt_ready),
    .cmd_out    (cmd_out),
    .cmd_valid  (cmd_valid),
    .tx_done    (tx_done),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [1:0] q[$];
  int         cyc       = 0;
  int         issue_e   = 0;
  int         idle_at   = -1;
  int         attempt   = 0;
  bit         in_flight = 1'b0;
  logic [1:0] last_cmd  = 2'b00;
  logic [1:0] m_cmd     = 2'b00;
  bit         m_valid   = 1'b0;
  bit         m_busy    = 1'b0;
  bit         m_ovf     = 1'b0;
  bit         m_terr    = 1'b0;

  // Stimulus knobs and observation log.
  int         ack_delay = 10;
  bit         ack_en    = 1'b1;
  bit         spur      = 1'b0;
  logic [1:0] seen_q[$];
  int         seen_cyc[$];
  bit         terr_seen;
  logic [LW-1:0] lvl_at_terr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit v, input logic [1:0] c, input bit d,
                            input bit clr, input bit r);
    bit issue;
    bit pop;
    bit dup;
    bit ovf_set;
    int n_pre;
    cyc++;
    if (r) begin
      q.delete();
      in_flight = 1'b0;
      attempt   = 0;
      idle_at   = cyc;
      m_cmd     = 2'b00;
      m_valid   = 1'b0;
      m_busy    = 1'b0;
      m_ovf     = 1'b0;
      m_terr    = 1'b0;
      last_cmd  = 2'b00;
    end else begin
      n_pre   = q.size();
      issue   = !in_flight && (cyc > idle_at) && (n_pre > 0);
      pop     = 1'b0;
      ovf_set = 1'b0;
      m_terr  = 1'b0;
      m_valid = 1'b0;
      // tx_done is honoured on edges issue+2 .. issue+1+T; deadline at issue+1+T.
      if (in_flight && (cyc >= issue_e + 2)) begin
        if (d) begin
          pop = 1'b1; attempt = 0; in_flight = 1'b0; idle_at = cyc + G;
        end else if (cyc == issue_e + 1 + T) begin
          in_flight = 1'b0; idle_at = cyc + G;
          if (attempt < R) attempt++;
          else begin pop = 1'b1; m_terr = 1'b1; attempt = 0; end
        end
      end
      if (issue) begin
        in_flight = 1'b1; issue_e = cyc; m_cmd = q[0]; m_valid = 1'b1;
      end
      dup = 1'b0;
`ifdef CMD_DEDUP_EN
      dup = v && (n_pre > 0) && (c == last_cmd);
`endif
      if (pop) void'(q.pop_front());
      if (v && !dup) begin
        if ((n_pre < DEPTH) || pop) begin
          q.push_back(c);
          last_cmd = c;
        end else begin
          ovf_set = 1'b1;
        end
      end
      if (clr) m_ovf = 1'b0;
      else if (ovf_set) m_ovf = 1'b1;
      m_busy = in_flight || (cyc < idle_at);
    end
  endtask

  // One clock: drive inputs, update model, sample at the falling edge and compare.
  task automatic step(input bit v, input logic [1:0] c, input bit clr, input bit r, input bit xd);
    bit d;
    d = ack_en && in_flight && ((cyc + 1) == (issue_e + ack_delay));
    if (spur && !in_flight && ($urandom_range(0, 7) == 0)) d = 1'b1;
    d = d | xd;
    evt_valid = v; evt_cmd = c; tx_done = d; ovf_clr = clr; sys_rst = r;
    model_edge(v, c, d, clr, r);
    @(posedge clk_50);
    @(negedge clk_50);
    chk("cmd_valid",   32'(cmd_valid),   32'(m_valid));
    chk("cmd_out",     32'(cmd_out),     32'(m_cmd));
    chk("busy",        32'(busy),        32'(m_busy));
    chk("fifo_level",  32'(fifo_level),  32'(q.size()));
    chk("evt_ready",   32'(evt_ready),   32'(q.size() < DEPTH));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (cmd_valid === 1'b1) begin
      seen_q.push_back(cmd_out);
      seen_cyc.push_back(cyc);
    end
  endtask

  initial begin
    @(negedge clk_50);
    // Reset state.
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Single command acknowledged 10 cycles after issue.
    seen_q.delete(); seen_cyc.delete();
    ack_en = 1'b1; ack_delay = 10;
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("t1_pulses", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() > 0) chk("t1_cmd", 32'(seen_q[0]), 32'd1);
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_level", 32'(fifo_level), 32'd0);

    // Three back-to-back pushes, each acknowledged.
    seen_q.delete(); seen_cyc.delete();
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("t2_pulses", 32'(seen_q.size()), 32'd3);
    for (int i = 0; i < seen_q.size(); i++) chk("t2_order", 32'(seen_q[i]), 32'(i + 1));
    for (int i = 1; i < seen_cyc.size(); i++)
      chk("t2_spacing", 32'((seen_cyc[i] - seen_cyc[i-1]) >= (G + 1)), 32'd1);

    // Nine pushes with no acknowledge: ninth overflows.
    seen_q.delete(); seen_cyc.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 9; i++) step(1'b1, 2'((i + 1) % 4), 1'b0, 1'b0, 1'b0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_ready", 32'(evt_ready), 32'd0);
    chk("t3_level", 32'(fifo_level), 32'd8);
    step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("t3_ovf_clr", 32'(overflow), 32'd0);

    // Same queue, still no acknowledge: three attempts then a drop.
    terr_seen = 1'b0; lvl_at_terr = '0;
    for (int i = 0; i < 400 && !terr_seen; i++) begin
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      if (timeout_err === 1'b1) begin
        terr_seen = 1'b1; lvl_at_terr = fifo_level;
      end
    end
    chk("t4_terr_seen", 32'(terr_seen), 32'd1);
    chk("t4_level", 32'(lvl_at_terr), 32'd7);
    chk("t4_pulses", 32'(seen_q.size()), 32'd3);
    for (int i = 0; i < seen_q.size(); i++) chk("t4_same_cmd", 32'(seen_q[i]), 32'd1);

    // Reset during WAIT_DONE with three queued; late tx_done ignored.
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("t5_level_pre", 32'(fifo_level), 32'd3);
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_valid", 32'(cmd_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    seen_q.delete(); seen_cyc.delete();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("t5_no_pulse", 32'(seen_q.size()), 32'd0);

    // Duplicate push while the first copy is pending.
    seen_q.delete(); seen_cyc.delete();
    ack_en = 1'b1; ack_delay = 5;
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef CMD_DEDUP_EN
    chk("t6_pulses", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() == 2) begin
      chk("t6_first", 32'(seen_q[0]), 32'd2);
      chk("t6_second", 32'(seen_q[1]), 32'd1);
    end
`else
    chk("t6_pulses", 32'(seen_q.size()), 32'd3);
    if (seen_q.size() == 3) begin
      chk("t6_first", 32'(seen_q[0]), 32'd2);
      chk("t6_second", 32'(seen_q[1]), 32'd2);
      chk("t6_third", 32'(seen_q[2]), 32'd1);
    end
`endif

    // Randomized traffic against the model.
    spur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit         v;
      bit         r;
      bit         clr;
      logic [1:0] c;
      v   = ($urandom_range(0, 2) == 0);
      c   = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 49) == 0);
      r   = ($urandom_range(0, 999) == 0);
      if (!in_flight) begin
        if ($urandom_range(0, 9) == 0) ack_delay = 150;
        else ack_delay = int'($urandom_range(1, 12));
      end
      step(v, c, clr, r, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
